// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU sharing controller.
package alu_arbiter_pkg;

  localparam int WIDTH_DEF = 8;

  // ALU component select encodings
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// whichever requester did not win last time.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant from the valid pair and the previous winner
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. One transaction is in
// flight at a time: accept in IDLE, capture the ALU result in ISSUE, hand it
// back in RESP until the owner takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             alu_select,
  output logic [WIDTH-1:0] alu_in_1,
  output logic [WIDTH-1:0] alu_in_2,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             op_r;
  logic [WIDTH-1:0] a_r, b_r, result_r;
  logic             owner_r;
  logic             last_grant;
  logic [1:0]       grant;
  logic             accept;
  logic             release_rsp;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Next state, handshakes and response qualifiers
  always_comb begin
    state_d     = state_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    accept      = 1'b0;
    release_rsp = 1'b0;
    case (state_q)
      IDLE: begin
        // ready only goes to the winner, so any grant is a handshake
        req0_ready = grant[0];
        req1_ready = grant[1];
        accept     = |grant;
        if (accept) state_d = ISSUE;
      end
      ISSUE: state_d = RESP;
      RESP: begin
        rsp0_valid  = ~owner_r;
        rsp1_valid  = owner_r;
        release_rsp = owner_r ? rsp1_ready : rsp0_ready;
        if (release_rsp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch, result capture and fairness history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_r       <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      result_r   <= '0;
      owner_r    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_r <= grant[1];
        op_r    <= grant[1] ? req1_op : req0_op;
        a_r     <= grant[1] ? req1_a  : req0_a;
        b_r     <= grant[1] ? req1_b  : req0_b;
      end
      if (state_q == ISSUE) result_r <= alu_out;
      if (release_rsp) last_grant <= owner_r;
    end
  end

  assign alu_select = op_r;
  assign alu_in_1   = a_r;
  assign alu_in_2   = b_r;
  assign rsp0_data  = result_r;
  assign rsp1_data  = result_r;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing and sharing controller for the 8-bit combinational ALU (add/multiply, 1-bit component select). It arbitrates between two requesters using round-robin priority and latches the winning operation. It drives the shared ALU from registered operands, captures the result, and returns it on a per-requester valid/ready response channel. It sits between the CPU control unit and a secondary requester, such as an address/loop unit, and the single ALU instance.

## Interface
Parameters:
- WIDTH, 8, datapath width of operands and result.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  1  operation select: 0 = add, 1 = multiply.
- req0_a  in  WIDTH  first operand.
- req0_b  in  WIDTH  second operand.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same widths and meaning for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp0_data  out  WIDTH  result for requester 0.
- rsp1_valid, rsp1_ready, rsp1_data: same widths and meaning for requester 1.
- alu_select  out  1  ALU component select, registered op.
- alu_in_1  out  WIDTH  ALU first operand, registered.
- alu_in_2  out  WIDTH  ALU second operand, registered.
- alu_out  in  WIDTH  ALU combinational result.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, ISSUE and RESP.
- **IDLE**
  - Winner is picked among asserted reqN_valid.
  - With a single valid, that requester wins.
  - With both valid, the requester other than last_grant wins.
  - reqN_ready is combinationally high only for the winner. Handshake is valid && ready.
  - On handshake: latch op, a, b and owner into op_r, a_r, b_r and owner_r, then go to ISSUE.
- **ISSUE**
  - alu_select/alu_in_1/alu_in_2 are driven from op_r/a_r/b_r, as they are in every state.
  - alu_out is captured into result_r at the clock edge, then go to RESP.
- **RESP**
  - rsp{owner_r}_valid = 1 and rsp{owner_r}_data = result_r. The other rsp_valid stays 0.
  - On rsp_ready: last_grant <= owner_r, then go to IDLE.
  - Data is held stable while ready is low.
- No reqN_ready is asserted outside IDLE, so there is exactly one transaction in flight.
- Arithmetic: the result is the low WIDTH bits of the ALU output, i.e. modulo 2^WIDTH. There is no carry or overflow flag.
- Requesters must hold valid and operands stable until ready. Changes before acceptance are simply re-evaluated each IDLE cycle.
- rspN_data outputs result_r for both N, qualified only by rspN_valid.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie).
  - op_r, a_r, b_r, result_r, owner_r = 0.
  - All ready/valid outputs and busy = 0. alu_select and alu_in_* = 0.
- Latency:
  - A request accepted in cycle N has rsp_valid high in cycle N+2.
  - With rsp_ready held high, the next accept is possible in cycle N+3, giving a peak throughput of 1 op per 3 cycles.
- Reset mid-operation (ISSUE or RESP): the transaction is dropped and no response is issued. From the next cycle the block is in the reset state.
- A request held across RESP is granted in the first IDLE cycle after the response handshake.
- Starvation-free: with both valid continuously, grants alternate 0, 1, 0, 1.

## Structure
- Package alu_arbiter_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - op encodings OP_ADD = 1'b0 and OP_MUL = 1'b1;
  - the default WIDTH constant.
- Sub-module rr_arb2 is the 2-way round-robin grant: inputs valid[1:0] and last_grant, output grant one-hot.
- The ALU itself is instantiated outside this block, by the integrating module.

## Test plan
- Reset, then req0 add 8'd3 + 8'd5 at cycle 0 -> req0_ready = 1 at cycle 0, alu_select = 0 at cycle 1, rsp0_valid = 1 with rsp0_data = 8'd8 at cycle 2, rsp1_valid = 0 throughout.
- req1 multiply 8'd20 * 8'd13 -> rsp1_data = 8'd4 (260 mod 256); req1 add 8'd200 + 8'd100 -> 8'd44.
- Both valid continuously from reset, rsp_ready tied high -> grant order 0, 1, 0, 1; each accept is 3 cycles apart.
- Hold rsp0_ready low for 5 cycles in RESP -> rsp0_valid and rsp0_data are stable, req1_ready stays 0 despite req1_valid, and busy = 1. Raising rsp0_ready -> IDLE next cycle, then req1 is accepted.
- Assert rst during ISSUE -> next cycle state = IDLE, no rspN_valid pulse, alu_in_* = 0, busy = 0.
- req0_valid pulses for one cycle while state is RESP -> no grant occurs; the request is not remembered.
